// File: rtl/divmod_arbiter.sv
// divmod_arbiter: round-robin sharing of one divmod unit among NREQ requesters,
// including error recovery. Define DIVMOD_ARB_TIMEOUT_EN to add the WAIT watchdog.
module divmod_arbiter #(
  parameter  int WIDTH_LOG = 4,
  parameter  int NREQ      = 4,
  parameter  int TIMEOUT   = 255,
  localparam int WIDTH     = 1 << WIDTH_LOG
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a_bus,
  input  logic [NREQ*WIDTH-1:0]   b_bus,
  output logic [NREQ-1:0]         ack,
  output logic                    err,
  output logic [WIDTH-1:0]        res,
  output logic                    busy,
  output logic                    dm_go,
  output logic                    dm_rst,
  output logic [WIDTH-1:0]        dm_a,
  output logic [WIDTH-1:0]        dm_b,
  input  logic                    dm_ready,
  input  logic                    dm_error,
  input  logic [WIDTH-1:0]        dm_mod
);

  localparam int IDXW = $clog2(NREQ);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_DLY = 3'd2,
    WAIT     = 3'd3,
    DONE     = 3'd4,
    ERR      = 3'd5
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [IDXW-1:0]   ptr_r, ptr_nxt_s;
  logic [IDXW-1:0]   winner_r, winner_nxt_s;
  logic [IDXW-1:0]   grant_idx_s;
  logic              grant_found_s;
  logic              grant_hit_s;
  logic [IDXW:0]     cand_s;
  logic [NREQ-1:0]   ack_r, ack_nxt_s;
  logic              err_r, err_nxt_s;
  logic              dm_go_r, dm_go_nxt_s;
  logic              dm_rst_r, dm_rst_nxt_s;
  logic [WIDTH-1:0]  res_r, res_nxt_s;
  logic [WIDTH-1:0]  dm_a_r, dm_a_nxt_s;
  logic [WIDTH-1:0]  dm_b_r, dm_b_nxt_s;
  logic              tmo_hit_s;

  function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = {NREQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] idx);
    if (idx == IDXW'(NREQ - 1)) begin
      return {IDXW{1'b0}};
    end else begin
      return idx + IDXW'(1);
    end
  endfunction

`ifdef DIVMOD_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);
  logic [7:0] tmo_cnt_r;

  // Watchdog counter: cleared on the way into WAIT, counts each WAIT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_r <= 8'd0;
    end else if (state_r == WAIT_DLY) begin
      tmo_cnt_r <= 8'd0;
    end else if (state_r == WAIT) begin
      tmo_cnt_r <= tmo_cnt_r + 8'd1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  assign tmo_hit_s = (tmo_cnt_r == TMO_LIMIT);
`else
  localparam int timeout_unused = TIMEOUT;
  assign tmo_hit_s = 1'b0;
`endif

  // Round-robin pick: scan from the farthest offset down so the nearest to ptr wins.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {IDXW{1'b0}};
    grant_hit_s   = 1'b0;
    cand_s        = {(IDXW+1){1'b0}};
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand_s        = {1'b0, ptr_r} + (IDXW+1)'(off);
      cand_s        = (cand_s >= (IDXW+1)'(NREQ)) ? cand_s - (IDXW+1)'(NREQ) : cand_s;
      grant_hit_s   = req[cand_s[IDXW-1:0]];
      grant_found_s = grant_found_s | grant_hit_s;
      grant_idx_s   = grant_hit_s ? cand_s[IDXW-1:0] : grant_idx_s;
    end
  end

  // Sequencer next state together with next values of every output register.
  always_comb begin
    state_nxt_s  = state_r;
    ptr_nxt_s    = ptr_r;
    winner_nxt_s = winner_r;
    ack_nxt_s    = {NREQ{1'b0}};
    err_nxt_s    = 1'b0;
    dm_go_nxt_s  = 1'b0;
    dm_rst_nxt_s = 1'b0;
    res_nxt_s    = res_r;
    dm_a_nxt_s   = dm_a_r;
    dm_b_nxt_s   = dm_b_r;
    case (state_r)
      IDLE: begin
        if (grant_found_s) begin
          state_nxt_s  = ISSUE;
          dm_go_nxt_s  = 1'b1;
          winner_nxt_s = grant_idx_s;
          dm_a_nxt_s   = a_bus[grant_idx_s*WIDTH +: WIDTH];
          dm_b_nxt_s   = b_bus[grant_idx_s*WIDTH +: WIDTH];
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE:    state_nxt_s = WAIT_DLY;
      WAIT_DLY: state_nxt_s = WAIT;
      WAIT: begin
        // A hard error beats ready; the watchdog only fires when ready is absent.
        if (dm_error || (!dm_ready && tmo_hit_s)) begin
          state_nxt_s  = ERR;
          ack_nxt_s    = onehot(winner_r);
          err_nxt_s    = 1'b1;
          res_nxt_s    = {WIDTH{1'b0}};
          dm_rst_nxt_s = 1'b1;
        end else if (dm_ready) begin
          state_nxt_s = DONE;
          ack_nxt_s   = onehot(winner_r);
          res_nxt_s   = dm_mod;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DONE, ERR: begin
        state_nxt_s = IDLE;
        ptr_nxt_s   = next_idx(winner_r);
      end
      default: begin
        state_nxt_s  = state_t'(3'bx);
        ptr_nxt_s    = {IDXW{1'bx}};
        winner_nxt_s = {IDXW{1'bx}};
        res_nxt_s    = {WIDTH{1'bx}};
        dm_a_nxt_s   = {WIDTH{1'bx}};
        dm_b_nxt_s   = {WIDTH{1'bx}};
      end
    endcase
  end

  // State and output registers; reset holds divmod in reset one cycle past rst_n.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      ptr_r    <= {IDXW{1'b0}};
      winner_r <= {IDXW{1'b0}};
      ack_r    <= {NREQ{1'b0}};
      err_r    <= 1'b0;
      dm_go_r  <= 1'b0;
      dm_rst_r <= 1'b1;
      res_r    <= {WIDTH{1'b0}};
      dm_a_r   <= {WIDTH{1'b0}};
      dm_b_r   <= {WIDTH{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      ptr_r    <= ptr_nxt_s;
      winner_r <= winner_nxt_s;
      ack_r    <= ack_nxt_s;
      err_r    <= err_nxt_s;
      dm_go_r  <= dm_go_nxt_s;
      dm_rst_r <= dm_rst_nxt_s;
      res_r    <= res_nxt_s;
      dm_a_r   <= dm_a_nxt_s;
      dm_b_r   <= dm_b_nxt_s;
    end
  end

  assign ack    = ack_r;
  assign err    = err_r;
  assign res    = res_r;
  assign busy   = (state_r != IDLE);
  assign dm_go  = dm_go_r;
  assign dm_rst = dm_rst_r;
  assign dm_a   = dm_a_r;
  assign dm_b   = dm_b_r;

endmodule
